// File: rtl/attn_score_accum_if.sv
// Score output stream of attn_score_accum: head-of-buffer score and spike
// with a valid/ready handshake. master = producer, slave = consumer.
interface attn_score_accum_if #(
    parameter int ACC_W = 9
);
    logic [ACC_W-1:0] o_Score;
    logic             o_Spike;
    logic             o_Score_valid;
    logic             i_Score_ready;

    modport master (
        output o_Score,
        output o_Spike,
        output o_Score_valid,
        input  i_Score_ready
    );

    modport slave (
        input  o_Score,
        input  o_Spike,
        input  o_Score_valid,
        output i_Score_ready
    );
endinterface

// File: rtl/attn_score_accum.sv
// Accumulates WORDS partial spike popcounts into one attention score,
// thresholds it and queues {score, spike} in a 2-entry FWFT buffer.
// Ports: s_clk, s_rst (sync, active high); i_SpikeSum/i_SpikeSum_valid
// partial-sum input; i_Clear frame start; i_Threshold spike threshold;
// o_out score stream (master); o_Overflow sticky drop flag; o_Busy.
module attn_score_accum #(
    parameter int SUM_W = 6,
    parameter int WORDS = 8,
    parameter int ACC_W = 9,
    parameter int CNT_W = 3
) (
    input  logic                   s_clk,
    input  logic                   s_rst,
    input  logic [SUM_W-1:0]       i_SpikeSum,
    input  logic                   i_SpikeSum_valid,
    input  logic                   i_Clear,
    input  logic [ACC_W-1:0]       i_Threshold,
    attn_score_accum_if.master     o_out,
    output logic                   o_Overflow,
    output logic                   o_Busy
);

    typedef struct packed {
        logic [ACC_W-1:0] score;
        logic             spike;
    } entry_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           mem_q [2];
    entry_t           mem_d [2];
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [1:0]       occ_q, occ_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] score;
    logic             take;
    logic             push;
    logic             pop;
    logic             drop;

    always_comb begin
        take  = i_SpikeSum_valid && !i_Clear;
        // Word 0 starts a fresh score regardless of acc contents.
        base  = (cnt_q == '0) ? '0 : acc_q;
        score = base + ACC_W'(i_SpikeSum);
        push  = take && (cnt_q == LAST);
        pop   = (occ_q != 2'd0) && o_out.i_Score_ready;
        // A pop in the same cycle frees a slot, so a full push is kept.
        drop  = push && (occ_q == 2'd2) && !pop;

        acc_d = acc_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        ovf_d = ovf_q;

        if (i_Clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            if (push) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = score;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (pop) begin
            rd_d = ~rd_q;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (push) begin
            mem_d[wr_q].score = score;
            mem_d[wr_q].spike = (score >= i_Threshold);
            wr_d = ~wr_q;
        end

        occ_d = occ_q
              + {1'b0, push && !drop}
              - {1'b0, pop};
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            occ_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_out.o_Score       = mem_q[rd_q].score;
    assign o_out.o_Spike       = mem_q[rd_q].spike;
    assign o_out.o_Score_valid = (occ_q != 2'd0);
    assign o_Overflow          = ovf_q;
    assign o_Busy              = (cnt_q != '0);

endmodule

// File: tb/tb_attn_score_accum.sv
// Self-checking bench for attn_score_accum: vector table, directed
// buffer/clear/reset sequences and randomized traffic vs a queue model.
module tb_attn_score_accum;

    localparam int SUM_W = 6;
    localparam int WORDS = 8;
    localparam int ACC_W = 9;
    localparam int CNT_W = 3;

    logic             s_clk = 1'b0;
    logic             s_rst;
    logic [SUM_W-1:0] sum;
    logic             valid;
    logic             clear;
    logic [ACC_W-1:0] thr;
    logic             ovf;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #5 s_clk = ~s_clk;

    attn_score_accum_if #(.ACC_W(ACC_W)) sif ();

    attn_score_accum #(
        .SUM_W(SUM_W),
        .WORDS(WORDS),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_SpikeSum      (sum),
        .i_SpikeSum_valid(valid),
        .i_Clear         (clear),
        .i_Threshold     (thr),
        .o_out           (sif),
        .o_Overflow      (ovf),
        .o_Busy          (busy)
    );

    // Reference model: words of the current score, output queue, sticky flag.
    typedef struct {
        int score;
        bit spike;
    } ent_t;

    int   m_words[$];
    ent_t m_fifo[$];
    bit   m_ovf;

    task automatic model_tick();
        bit   popped;
        int   tot;
        ent_t e;
        if (s_rst) begin
            m_words.delete();
            m_fifo.delete();
            m_ovf = 0;
            return;
        end
        popped = (m_fifo.size() > 0) && sif.i_Score_ready;
        if (popped) void'(m_fifo.pop_front());
        if (clear) begin
            m_words.delete();
        end else if (valid) begin
            m_words.push_back(int'(sum));
            if (m_words.size() == WORDS) begin
                tot = 0;
                foreach (m_words[i]) tot += m_words[i];
                m_words.delete();
                e.score = tot;
                e.spike = (tot >= int'(thr));
                if (m_fifo.size() < 2) m_fifo.push_back(e);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_model();
        bit ev;
        bit bad;
        int es;
        bit esp;
        ev  = (m_fifo.size() > 0);
        es  = ev ? m_fifo[0].score : 0;
        esp = ev ? m_fifo[0].spike : 1'b0;
        bad = (sif.o_Score_valid !== ev) || (ovf !== m_ovf)
            || (busy !== (m_words.size() != 0));
        if (ev && (int'(sif.o_Score) != es || sif.o_Spike !== esp)) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL model t=%0t: got v=%0b s=%0d sp=%0b ov=%0b bz=%0b, want v=%0b s=%0d sp=%0b ov=%0b bz=%0b",
                     $time, sif.o_Score_valid, sif.o_Score, sif.o_Spike, ovf, busy,
                     ev, es, esp, m_ovf, m_words.size() != 0);
        end
    endtask

    task automatic step(bit v, int s, bit c, bit rdy);
        valid = v;
        sum   = SUM_W'(s);
        clear = c;
        sif.i_Score_ready = rdy;
        @(posedge s_clk);
        model_tick();
        #1;
        check_model();
    endtask

    task automatic expect_out(string tag, bit v, int sc, bit sp,
                              bit ov, bit bz, bit data);
        bit bad;
        bad = (sif.o_Score_valid !== v) || (ovf !== ov) || (busy !== bz);
        if (data && (int'(sif.o_Score) != sc || sif.o_Spike !== sp)) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s: got v=%0b s=%0d sp=%0b ov=%0b bz=%0b, want v=%0b s=%0d sp=%0b ov=%0b bz=%0b",
                     tag, sif.o_Score_valid, sif.o_Score, sif.o_Spike, ovf, busy,
                     v, sc, sp, ov, bz);
        end
    endtask

    task automatic feed(int total, bit rdy, bit rdy_last);
        int w0;
        w0 = (total > 32) ? 32 : total;
        for (int i = 0; i < WORDS; i++) begin
            step(1, (i == 0) ? w0 : ((i == 1) ? total - w0 : 0), 0,
                 (i == WORDS - 1) ? rdy_last : rdy);
        end
    endtask

    task automatic do_reset();
        s_rst = 1;
        step(0, 0, 0, 0);
        s_rst = 0;
    endtask

    typedef struct {
        int w[WORDS];
        int gap;
        int thr;
        int exp_score;
        bit exp_spike;
    } vec_t;

    vec_t tbl[6];

    initial begin
        s_rst = 1;
        valid = 0;
        sum   = '0;
        clear = 0;
        thr   = '0;
        sif.i_Score_ready = 0;

        tbl[0] = '{w: '{default: 32}, gap: 0, thr: 128, exp_score: 256, exp_spike: 1};
        tbl[1] = '{w: '{3, 0, 5, 1, 0, 2, 4, 1}, gap: 2, thr: 17, exp_score: 16, exp_spike: 0};
        tbl[2] = '{w: '{3, 0, 5, 1, 0, 2, 4, 1}, gap: 2, thr: 16, exp_score: 16, exp_spike: 1};
        tbl[3] = '{w: '{default: 0}, gap: 1, thr: 0, exp_score: 0, exp_spike: 1};
        tbl[4] = '{w: '{default: 32}, gap: 0, thr: 257, exp_score: 256, exp_spike: 0};
        tbl[5] = '{w: '{default: 1}, gap: 3, thr: 8, exp_score: 8, exp_spike: 1};

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        s_rst = 0;
        expect_out("reset", 0, 0, 0, 0, 0, 1);

        foreach (tbl[k]) begin
            thr = ACC_W'(tbl[k].thr);
            for (int i = 0; i < WORDS; i++) begin
                step(1, tbl[k].w[i], 0, 1);
                if (i != WORDS - 1) begin
                    for (int g = 0; g < tbl[k].gap; g++) step(0, 0, 0, 1);
                end
            end
            expect_out($sformatf("vec%0d_out", k), 1, tbl[k].exp_score,
                       tbl[k].exp_spike, 0, 0, 1);
            step(0, 0, 0, 1);
            expect_out($sformatf("vec%0d_pulse", k), 0, 0, 0, 0, 0, 0);
        end

        // Three scores with no consumer: third is dropped.
        do_reset();
        thr = 9'd15;
        feed(10, 0, 0);
        feed(20, 0, 0);
        feed(30, 0, 0);
        expect_out("ovf_head10", 1, 10, 0, 1, 0, 1);
        step(0, 0, 0, 1);
        expect_out("ovf_head20", 1, 20, 1, 1, 0, 1);
        step(0, 0, 0, 1);
        expect_out("ovf_empty", 0, 0, 0, 1, 0, 0);

        // Full buffer, pop in the same cycle the next score completes.
        do_reset();
        feed(10, 0, 0);
        feed(20, 0, 0);
        feed(40, 0, 1);
        expect_out("full_pp_head20", 1, 20, 1, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("full_pp_head40", 1, 40, 1, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("full_pp_empty", 0, 0, 0, 0, 0, 0);

        // Clear mid-score, with a valid word in the clear cycle.
        do_reset();
        thr = 9'd5;
        for (int i = 0; i < 5; i++) step(1, 7, 0, 1);
        expect_out("clr_busy", 0, 0, 0, 0, 1, 0);
        step(1, 7, 1, 1);
        expect_out("clr_idle", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WORDS; i++) step(1, 1, 0, 1);
        expect_out("clr_score8", 1, 8, 1, 0, 0, 1);

        // Reset with a buffered score and a partial score in flight.
        do_reset();
        thr = 9'd15;
        feed(10, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
        expect_out("rst_pre", 1, 10, 0, 0, 1, 1);
        do_reset();
        expect_out("rst_zero", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < WORDS; i++) step(1, 2, 0, 1);
        expect_out("rst_score16", 1, 16, 1, 0, 0, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) thr = ACC_W'($urandom_range(0, 300));
            s_rst = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 32),
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6);
        end
        s_rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/attn_score_accum.md
Name: attn_score_accum

Overview:
- Sits directly downstream of the pipelined spike popcount adder in the attention-calculation path.
- Consumes one partial spike sum per valid cycle (popcount of one 32-bit Q AND K spike word).
- Accumulates WORDS partial sums into one attention score, compares the score against a runtime threshold, and emits score plus spike through a 2-entry output buffer with a valid/ready handshake.

Parameters:
- SUM_W, 6, width of incoming partial sum (range 0..32)
- WORDS, 8, partial sums per score (head dim / 32); must be >= 1
- ACC_W, 9, score width; must hold WORDS*32 (default max 256)
- CNT_W, 3, word counter width, clog2(WORDS), minimum 1

Ports:
- s_clk  in  1  clock
- s_rst  in  1  synchronous active-high reset
- i_SpikeSum  in  SUM_W  partial popcount from upstream adder
- i_SpikeSum_valid  in  1  partial sum valid; no backpressure to upstream
- i_Clear  in  1  frame start: discard in-progress accumulation
- i_Threshold  in  ACC_W  spike threshold, sampled when a score is pushed
- o_Score  out  ACC_W  head-of-buffer score
- o_Spike  out  1  head-of-buffer spike, set when score >= threshold
- o_Score_valid  out  1  buffer not empty
- i_Score_ready  in  1  consumer accepts the head entry
- o_Overflow  out  1  sticky: a completed score was dropped
- o_Busy  out  1  accumulation in progress (word counter != 0)

Behaviour:
- Reset: all outputs 0. Accumulator, word counter and buffer pointers are cleared; the buffer is empty.
- Reset is synchronous only and takes priority over every other input. Reset mid-accumulation discards the partial score and clears o_Overflow.
- Accumulation, for each cycle with i_SpikeSum_valid=1:
  - On words 0..WORDS-2: acc <= acc + i_SpikeSum (word 0 loads acc <= i_SpikeSum); cnt increments.
  - On word WORDS-1: the score (acc + i_SpikeSum) is written to the buffer; acc <= 0, cnt <= 0.
- Gaps: cycles with valid=0 hold acc and cnt. Gaps of any length between words are legal.
- Arithmetic: i_SpikeSum is zero-extended to ACC_W. No saturation is required, because ACC_W is sized for the maximum sum.
- Spike: computed at push as (score >= i_Threshold) using the i_Threshold value in that same cycle, and stored alongside the score.
- Latency: the final word is valid at cycle N; o_Score_valid and the data appear at cycle N+1 if the buffer was empty.
- i_Clear:
  - acc <= 0, cnt <= 0 next cycle; any valid word in the same cycle is ignored.
  - The buffer contents and o_Overflow are unaffected.
- Buffer: 2-entry FIFO, first-word-fall-through.
  - Pop when o_Score_valid and i_Score_ready are both 1.
  - o_Score/o_Spike stay stable while valid=1 and ready=0.
- Push into a full buffer with no pop in the same cycle: the score is dropped, o_Overflow <= 1 (sticky until s_rst), and buffer contents are unchanged.
- Push and pop in the same cycle when full: accepted, no overflow; occupancy stays 2 and order is preserved.
- Push and pop in the same cycle when occupancy is 1: occupancy stays 1 and the new entry becomes head next cycle.
- Pop when empty: ignored.
- o_Busy = (cnt != 0).

Test Plan:
- Default params, threshold=128, ready=1, 8 back-to-back valid sums of 32 -> one cycle after the 8th, o_Score=256, o_Spike=1, o_Score_valid pulses for 1 cycle, o_Overflow=0.
- Sums 3,0,5,1,0,2,4,1 with a 2-cycle idle gap after each word, threshold=17 -> o_Score=16, o_Spike=0; then threshold=16 with the same data -> o_Score=16, o_Spike=1.
- ready=0, three complete scores (values 10, 20, 30) -> buffer holds 10, 20; the third is dropped and o_Overflow=1; ready=1 -> pops 10 then 20, o_Overflow remains 1.
- Buffer full (10, 20), ready=1 in the same cycle the score 40 completes -> pops 10; buffer holds 20, 40; o_Overflow=0.
- After 5 words of value 7, assert i_Clear, then 8 words of value 1 -> o_Score=8 (not 43); o_Busy is 0 the cycle after the clear.
- After 4 words, assert s_rst for 1 cycle while a score is buffered -> all outputs 0; the next 8 words of value 2 produce o_Score=16.
